key_fifo: RTL and testbench

Parameterised synchronous FIFO that sits directly downstream of the push-button edge detector in the FIFO lab datapath. It consumes the detector's one-cycle write and read strobes and stores a switch-supplied data word on each write. It presents the oldest word on a registered read port on each read. It reports occupancy, full/empty, and one-cycle error pulses for rejected operations.

---
 rtl/key_fifo.sv | 105 ++++++++++
 tb/tb_key_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/key_fifo.sv
// Synchronous FIFO fed by the push-button edge detector: stores a word per write strobe,
// returns the oldest word on a registered read port, and flags rejected strobes.
module key_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;

    logic empty_w;
    logic full_w;
    logic rd_ok;
    logic wr_ok;

    // Flags decode only the count register, so they cannot glitch with the strobes.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_CNT);

    // A read frees a slot in the same edge, so a write on a full FIFO succeeds alongside it.
    assign rd_ok = rd & ~empty_w;
    assign wr_ok = wr & (~full_w | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        r_data_d = r_data_q;
        wr_err_d = 1'b0;
        rd_err_d = 1'b0;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            r_data_d = mem_q[rd_ptr_q];
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        wr_err_d = wr & ~wr_ok;
        rd_err_d = rd & ~rd_ok;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            r_data_q <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            r_data_q <= r_data_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage is left uncleared by reset; a strobe coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    assign r_data = r_data_q;
    assign count  = count_q;
    assign empty  = empty_w;
    assign full   = full_w;
    assign wr_err = wr_err_q;
    assign rd_err = rd_err_q;

endmodule

// File: tb/tb_key_fifo.sv
// Directed self-checking bench for key_fifo: ordering, overflow, underflow,
// simultaneous strobes, pointer wrap and reset during operation.
module tb_key_fifo;

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic       rd;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       wr_err;
    logic       rd_err;

    int total;
    int bad;

    key_fifo #(
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .rd      (rd),
        .w_data  (w_data),
        .r_data  (r_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .wr_err  (wr_err),
        .rd_err  (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one set of strobes across one clock edge, then settle for sampling.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr     = w;
        rd     = r;
        w_data = d;
        @(posedge clk);
        #1;
        $display("cyc wr=%0b rd=%0b w_data=%02h -> r_data=%02h count=%0d empty=%0b full=%0b wr_err=%0b rd_err=%0b",
                 w, r, d, r_data, count, empty, full, wr_err, rd_err);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        w_data  = 8'h00;

        // Reset state
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("rst_r_data", 32'(r_data), 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_rd_err", 32'(rd_err), 32'd0);
        reset_n = 1'b1;

        // Basic order
        cyc(1'b1, 1'b0, 8'h11); chk("basic_cnt1", 32'(count), 32'd1);
        chk("basic_empty_lo", 32'(empty), 32'd0);
        cyc(1'b1, 1'b0, 8'h22); chk("basic_cnt2", 32'(count), 32'd2);
        cyc(1'b1, 1'b0, 8'h33); chk("basic_cnt3", 32'(count), 32'd3);
        cyc(1'b0, 1'b1, 8'h00); chk("basic_rd1", 32'(r_data), 32'h11); chk("basic_c2", 32'(count), 32'd2);
        cyc(1'b0, 1'b1, 8'h00); chk("basic_rd2", 32'(r_data), 32'h22); chk("basic_c1", 32'(count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00); chk("basic_rd3", 32'(r_data), 32'h33); chk("basic_c0", 32'(count), 32'd0);
        chk("basic_empty", 32'(empty), 32'd1);
        chk("basic_errs", 32'({wr_err, rd_err}), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("fill_cnt", 32'(count), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b0, 8'hAA);
        chk("ovf_wr_err", 32'(wr_err), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd16);
        cyc(1'b0, 1'b0, 8'h00);
        chk("ovf_wr_err_clr", 32'(wr_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("drain_data", 32'(r_data), 32'(i));
            chk("drain_cnt", 32'(count), 32'(15 - i));
        end

        // Underflow
        cyc(1'b0, 1'b1, 8'h00);
        chk("unf_rd_err", 32'(rd_err), 32'd1);
        chk("unf_r_data", 32'(r_data), 32'h0F);
        chk("unf_cnt", 32'(count), 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("unf_rd_err_clr", 32'(rd_err), 32'd0);

        // Simultaneous strobes on full
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        chk("sim_full_pre", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 8'h55);
        chk("sim_full_head", 32'(r_data), 32'h80);
        chk("sim_full_cnt", 32'(count), 32'd16);
        chk("sim_full_errs", 32'({wr_err, rd_err}), 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            chk("sim_drain", 32'(r_data), 32'(8'h80 + i));
        end
        cyc(1'b0, 1'b1, 8'h00);
        chk("sim_last_55", 32'(r_data), 32'h55);
        chk("sim_drained", 32'(empty), 32'd1);

        // Simultaneous strobes on empty
        cyc(1'b1, 1'b1, 8'h77);
        chk("sim_emp_rd_err", 32'(rd_err), 32'd1);
        chk("sim_emp_wr_err", 32'(wr_err), 32'd0);
        chk("sim_emp_cnt", 32'(count), 32'd1);
        chk("sim_emp_r_data", 32'(r_data), 32'h55);
        cyc(1'b0, 1'b1, 8'h00);
        chk("sim_emp_rd", 32'(r_data), 32'h77);
        chk("sim_emp_cnt0", 32'(count), 32'd0);

        // Wrap-around
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk("wrap_cnt1", 32'(count), 32'd1);
            cyc(1'b0, 1'b1, 8'h00);
            chk("wrap_data", 32'(r_data), 32'(i));
            chk("wrap_cnt0", 32'(count), 32'd0);
        end

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        chk("mid_pre_cnt", 32'(count), 32'd5);
        reset_n = 1'b0;
        cyc(1'b1, 1'b0, 8'h99);
        reset_n = 1'b1;
        chk("mid_cnt", 32'(count), 32'd0);
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_r_data", 32'(r_data), 32'h0);
        chk("mid_errs", 32'({wr_err, rd_err}), 32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("mid_rd_err", 32'(rd_err), 32'd1);
        chk("mid_rd_data", 32'(r_data), 32'h0);
        chk("mid_rd_cnt", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
